// File: rtl/md_pkg.sv
// Multiply/divide op encodings shared by the decoder, stall logic and the E-stage unit.
package md_pkg;

    localparam int MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

    function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 product and quotient/remainder; result is written back only when o_wb is set.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [31:0]        i_a,
    input  logic [31:0]        i_b,
    output logic [31:0]        o_hi,
    output logic [31:0]        o_lo,
    output logic               o_wb
);

    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_b;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_prod;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);

    // Sign-extending to 64 bits makes the low 64 bits of the product correct for both signednesses.
    assign w_prod = (w_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a}) *
                    (w_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b});

    // Magnitude division; 0x80000000 / -1 wraps back to 0x80000000 with a zero remainder.
    assign w_neg_a = w_signed & i_a[31];
    assign w_neg_b = w_signed & i_b[31];
    assign w_abs_a = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_abs_b = w_neg_b ? (32'd0 - i_b) : i_b;
    assign w_div_b = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_q_u   = w_abs_a / w_div_b;
    assign w_r_u   = w_abs_a % w_div_b;
    assign w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_u) : w_q_u;
    assign w_r     = w_neg_a ? (32'd0 - w_r_u) : w_r_u;

    assign o_hi = md_is_div(i_op) ? w_r : w_prod[63:32];
    assign o_lo = md_is_div(i_op) ? w_q : w_prod[31:0];
    assign o_wb = !(md_is_div(i_op) && (i_b == 32'd0));

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency busy FSM, move to/from HI/LO.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [MD_OP_W-1:0] E_MD_op,
    input  logic [31:0]        E_A,
    input  logic [31:0]        E_B,
    output logic               start,
    output logic               busy,
    output logic [31:0]        E_MD_out
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_temp_hi;
    logic [31:0]        r_temp_lo;
    logic               r_temp_wb;

    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_wb;
    logic               w_start;

    md_arith u_arith (
        .i_op (E_MD_op),
        .i_a  (E_A),
        .i_b  (E_B),
        .o_hi (w_res_hi),
        .o_lo (w_res_lo),
        .o_wb (w_res_wb)
    );

    assign w_start = md_is_arith(E_MD_op) && !r_busy && !req;
    assign start   = w_start;
    assign busy    = r_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_temp_wb <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_temp_hi <= w_res_hi;
                        r_temp_lo <= w_res_lo;
                        r_temp_wb <= w_res_wb;
                        r_cnt     <= md_is_div(E_MD_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else if (!req && (E_MD_op == MD_MTHI)) begin
                        r_hi <= E_A;
                    end else if (!req && (E_MD_op == MD_MTLO)) begin
                        r_lo <= E_A;
                    end
                end
                S_RUN: begin
                    // Ops presented while running are ignored; req does not abort the in-flight op.
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_temp_wb) begin
                            r_hi <= r_temp_hi;
                            r_lo <= r_temp_lo;
                        end
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        E_MD_out = 32'd0;
        case (E_MD_op)
            MD_MFHI: E_MD_out = r_hi;
            MD_MFLO: E_MD_out = r_lo;
            default: E_MD_out = 32'd0;
        endcase
    end

endmodule
